// File: rtl/game_outcome_fsm.sv
// game_outcome_fsm
//   Registered end-of-game arbiter. Tracks a SAFE/CHECK/MATED/STALE state
//   machine per side and folds mate, stalemate, resignation, flag-fall, the
//   halfmove rule and an optional full-move cap into one sticky outcome.
//
// Ports
//   clk, reset          : clock; asynchronous active-high reset
//   new_game            : synchronous restart (same effect as reset)
//   eval_valid          : strobe, in_check/has_legal_move valid for side_to_move
//   side_to_move        : 0 white, 1 black
//   in_check            : king of side_to_move attacked
//   has_legal_move      : side_to_move has a legal move
//   move_done           : strobe, side_to_move completed a move
//   move_resets_clock   : qualifies move_done (pawn move or capture)
//   resign_white/black  : resignation requests
//   flag_white/black    : clock expired
//   win_state           : 00 CONTINUE, 01 WHITEWIN, 10 BLACKWIN, 11 DRAW
//   end_reason          : 0 NONE 1 MATE 2 STALE 3 HALFMOVE 4 RESIGN 5 TIMEOUT 6 MOVE_CAP
//   game_over           : sticky end flag
//   check_white/black   : that king currently in check
//   halfmove_cnt        : halfmove clock
//   fullmove_cnt        : full-move number, starts at 1
module game_outcome_fsm #(
  parameter int HALFMOVE_LIMIT = 100,
  parameter int HM_W           = 7,
  parameter int MAX_FULLMOVES  = 0,
  parameter int FM_W           = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            new_game,
  input  logic            eval_valid,
  input  logic            side_to_move,
  input  logic            in_check,
  input  logic            has_legal_move,
  input  logic            move_done,
  input  logic            move_resets_clock,
  input  logic            resign_white,
  input  logic            resign_black,
  input  logic            flag_white,
  input  logic            flag_black,
  output logic [1:0]      win_state,
  output logic [2:0]      end_reason,
  output logic            game_over,
  output logic            check_white,
  output logic            check_black,
  output logic [HM_W-1:0] halfmove_cnt,
  output logic [FM_W-1:0] fullmove_cnt
);

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    CHECK = 2'd1,
    MATED = 2'd2,
    STALE = 2'd3
  } side_state_t;

  localparam logic [HM_W-1:0] HM_ONE = {{(HM_W-1){1'b0}}, 1'b1};
  localparam logic [FM_W-1:0] FM_ONE = {{(FM_W-1){1'b0}}, 1'b1};

  side_state_t     r_st_w, r_st_b, w_st_w_nxt, w_st_b_nxt;
  logic [HM_W-1:0] r_hm, w_hm_nxt;
  logic [FM_W-1:0] r_fm, w_fm_nxt;
  logic [1:0]      r_ws, w_ws_nxt;
  logic [2:0]      r_er, w_er_nxt;
  logic            r_over, w_over_nxt;
  logic            w_mate_w, w_mate_b, w_stale;

  // Evaluation result for the side to move; MATED/STALE never leave.
  function automatic side_state_t eval_next(input side_state_t cur,
                                            input logic chk,
                                            input logic legal);
    side_state_t nxt;
    if ((cur == MATED) || (cur == STALE)) begin
      nxt = cur;
    end else begin
      case ({chk, legal})
        2'b11:   nxt = CHECK;
        2'b01:   nxt = SAFE;
        2'b10:   nxt = MATED;
        default: nxt = STALE;
      endcase
    end
    return nxt;
  endfunction

  // Next-state: side FSMs, counters and the prioritised outcome decision.
  always_comb begin
    w_st_w_nxt = r_st_w;
    w_st_b_nxt = r_st_b;
    w_hm_nxt   = r_hm;
    w_fm_nxt   = r_fm;
    w_ws_nxt   = r_ws;
    w_er_nxt   = r_er;
    w_over_nxt = r_over;
    w_mate_w   = 1'b0;
    w_mate_b   = 1'b0;
    w_stale    = 1'b0;
    if (!r_over) begin
      // Counters update first so the outcome rules see post-move values.
      if (move_done) begin
        if (move_resets_clock) begin
          w_hm_nxt = '0;
        end else if (r_hm != {HM_W{1'b1}}) begin
          w_hm_nxt = r_hm + HM_ONE;
        end else begin
          w_hm_nxt = r_hm;
        end
        if (side_to_move && (r_fm != {FM_W{1'b1}})) begin
          w_fm_nxt = r_fm + FM_ONE;
        end else begin
          w_fm_nxt = r_fm;
        end
      end else begin
        w_hm_nxt = r_hm;
        w_fm_nxt = r_fm;
      end

      if (eval_valid) begin
        if (!side_to_move) begin
          w_st_w_nxt = eval_next(r_st_w, in_check, has_legal_move);
          w_st_b_nxt = SAFE;
        end else begin
          w_st_b_nxt = eval_next(r_st_b, in_check, has_legal_move);
          w_st_w_nxt = SAFE;
        end
      end else begin
        w_st_w_nxt = r_st_w;
        w_st_b_nxt = r_st_b;
      end

      w_mate_w = (w_st_w_nxt == MATED) && (r_st_w != MATED);
      w_mate_b = (w_st_b_nxt == MATED) && (r_st_b != MATED);
      w_stale  = ((w_st_w_nxt == STALE) && (r_st_w != STALE)) ||
                 ((w_st_b_nxt == STALE) && (r_st_b != STALE));

      if (w_mate_w) begin
        w_ws_nxt = 2'b10;
        w_er_nxt = 3'd1;
      end else if (w_mate_b) begin
        w_ws_nxt = 2'b01;
        w_er_nxt = 3'd1;
      end else if (w_stale) begin
        w_ws_nxt = 2'b11;
        w_er_nxt = 3'd2;
      end else if (resign_white || resign_black) begin
        w_ws_nxt = {resign_white, resign_black};
        w_er_nxt = 3'd4;
      end else if (flag_white || flag_black) begin
        w_ws_nxt = {flag_white, flag_black};
        w_er_nxt = 3'd5;
      end else if ((HALFMOVE_LIMIT != 0) && (32'(w_hm_nxt) >= HALFMOVE_LIMIT)) begin
        w_ws_nxt = 2'b11;
        w_er_nxt = 3'd3;
      end else if ((MAX_FULLMOVES != 0) && (32'(w_fm_nxt) > MAX_FULLMOVES)) begin
        w_ws_nxt = 2'b11;
        w_er_nxt = 3'd6;
      end else begin
        w_ws_nxt = 2'b00;
        w_er_nxt = 3'd0;
      end
      w_over_nxt = (w_ws_nxt != 2'b00);
    end else begin
      w_over_nxt = r_over;
    end
  end

  // State register; new_game overrides every other input in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_w <= SAFE;
      r_st_b <= SAFE;
      r_hm   <= '0;
      r_fm   <= FM_ONE;
      r_ws   <= 2'b00;
      r_er   <= 3'd0;
      r_over <= 1'b0;
    end else if (new_game) begin
      r_st_w <= SAFE;
      r_st_b <= SAFE;
      r_hm   <= '0;
      r_fm   <= FM_ONE;
      r_ws   <= 2'b00;
      r_er   <= 3'd0;
      r_over <= 1'b0;
    end else begin
      r_st_w <= w_st_w_nxt;
      r_st_b <= w_st_b_nxt;
      r_hm   <= w_hm_nxt;
      r_fm   <= w_fm_nxt;
      r_ws   <= w_ws_nxt;
      r_er   <= w_er_nxt;
      r_over <= w_over_nxt;
    end
  end

  assign win_state    = r_ws;
  assign end_reason   = r_er;
  assign game_over    = r_over;
  assign check_white  = (r_st_w == CHECK) || (r_st_w == MATED);
  assign check_black  = (r_st_b == CHECK) || (r_st_b == MATED);
  assign halfmove_cnt = r_hm;
  assign fullmove_cnt = r_fm;

endmodule

// File: tb/tb_game_outcome_fsm.sv
// Testbench for game_outcome_fsm. Two instances share the stimulus:
// instance 0 runs a 4-halfmove draw rule with no move cap, instance 1 runs
// a 2-full-move cap with the halfmove rule disabled.
module tb_game_outcome_fsm;

  logic clk = 1'b0;
  logic reset, new_game, eval_valid, side_to_move, in_check, has_legal_move;
  logic move_done, move_resets_clock, resign_white, resign_black;
  logic flag_white, flag_black;

  logic [1:0] ws [2];
  logic [2:0] er [2];
  logic       go [2];
  logic       cw [2];
  logic       cb [2];
  logic [6:0] hm [2];
  logic [8:0] fm [2];

  int n_pass = 0;
  int n_total = 0;

  // Reference model state, one entry per instance.
  int m_ws [2], m_er [2], m_over [2], m_cw [2], m_cb [2], m_hm [2], m_fm [2];
  int lim_hm [2] = '{4, 0};
  int lim_fm [2] = '{0, 2};

  always #5 clk = ~clk;

  game_outcome_fsm #(.HALFMOVE_LIMIT(4), .HM_W(7), .MAX_FULLMOVES(0), .FM_W(9)) u_dut0 (
    .clk(clk), .reset(reset), .new_game(new_game), .eval_valid(eval_valid),
    .side_to_move(side_to_move), .in_check(in_check), .has_legal_move(has_legal_move),
    .move_done(move_done), .move_resets_clock(move_resets_clock),
    .resign_white(resign_white), .resign_black(resign_black),
    .flag_white(flag_white), .flag_black(flag_black),
    .win_state(ws[0]), .end_reason(er[0]), .game_over(go[0]),
    .check_white(cw[0]), .check_black(cb[0]),
    .halfmove_cnt(hm[0]), .fullmove_cnt(fm[0]));

  game_outcome_fsm #(.HALFMOVE_LIMIT(0), .HM_W(7), .MAX_FULLMOVES(2), .FM_W(9)) u_dut1 (
    .clk(clk), .reset(reset), .new_game(new_game), .eval_valid(eval_valid),
    .side_to_move(side_to_move), .in_check(in_check), .has_legal_move(has_legal_move),
    .move_done(move_done), .move_resets_clock(move_resets_clock),
    .resign_white(resign_white), .resign_black(resign_black),
    .flag_white(flag_white), .flag_black(flag_black),
    .win_state(ws[1]), .end_reason(er[1]), .game_over(go[1]),
    .check_white(cw[1]), .check_black(cb[1]),
    .halfmove_cnt(hm[1]), .fullmove_cnt(fm[1]));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ws[i] = 0; m_er[i] = 0; m_over[i] = 0; m_cw[i] = 0; m_cb[i] = 0;
      m_hm[i] = 0; m_fm[i] = 1;
    end
  endfunction

  // One clock edge of the game rules, applied to both model instances.
  function automatic void model_step();
    bit mated, stale;
    for (int i = 0; i < 2; i++) begin
      if (new_game) begin
        m_ws[i] = 0; m_er[i] = 0; m_over[i] = 0; m_cw[i] = 0; m_cb[i] = 0;
        m_hm[i] = 0; m_fm[i] = 1;
      end else if (m_over[i] == 0) begin
        if (move_done) begin
          m_hm[i] = move_resets_clock ? 0 : ((m_hm[i] < 127) ? m_hm[i] + 1 : 127);
          if (side_to_move) m_fm[i] = (m_fm[i] < 511) ? m_fm[i] + 1 : 511;
        end
        mated = 0; stale = 0;
        if (eval_valid) begin
          if (side_to_move) begin m_cb[i] = in_check; m_cw[i] = 0; end
          else begin m_cw[i] = in_check; m_cb[i] = 0; end
          if (!has_legal_move) begin
            if (in_check) mated = 1; else stale = 1;
          end
        end
        if (mated) begin m_ws[i] = side_to_move ? 1 : 2; m_er[i] = 1; end
        else if (stale) begin m_ws[i] = 3; m_er[i] = 2; end
        else if (resign_white || resign_black) begin
          m_ws[i] = (resign_white && resign_black) ? 3 : (resign_white ? 2 : 1); m_er[i] = 4;
        end else if (flag_white || flag_black) begin
          m_ws[i] = (flag_white && flag_black) ? 3 : (flag_white ? 2 : 1); m_er[i] = 5;
        end else if (lim_hm[i] != 0 && m_hm[i] >= lim_hm[i]) begin m_ws[i] = 3; m_er[i] = 3; end
        else if (lim_fm[i] != 0 && m_fm[i] > lim_fm[i]) begin m_ws[i] = 3; m_er[i] = 6; end
        m_over[i] = (m_ws[i] != 0) ? 1 : 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s.ws%0d", tag, i), int'(ws[i]), m_ws[i]);
      check_val($sformatf("%s.er%0d", tag, i), int'(er[i]), m_er[i]);
      check_val($sformatf("%s.go%0d", tag, i), int'(go[i]), m_over[i]);
      check_val($sformatf("%s.cw%0d", tag, i), int'(cw[i]), m_cw[i]);
      check_val($sformatf("%s.cb%0d", tag, i), int'(cb[i]), m_cb[i]);
      check_val($sformatf("%s.hm%0d", tag, i), int'(hm[i]), m_hm[i]);
      check_val($sformatf("%s.fm%0d", tag, i), int'(fm[i]), m_fm[i]);
    end
  endtask

  task automatic clear_inputs();
    new_game = 0; eval_valid = 0; side_to_move = 0; in_check = 0; has_legal_move = 1;
    move_done = 0; move_resets_clock = 0; resign_white = 0; resign_black = 0;
    flag_white = 0; flag_black = 0;
  endtask

  // Apply the currently driven inputs for one clock, check, then idle them.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    clear_inputs();
  endtask

  task automatic do_eval(input bit s, input bit ic, input bit lg, input string tag);
    eval_valid = 1; side_to_move = s; in_check = ic; has_legal_move = lg;
    tick(tag);
  endtask

  task automatic do_move(input bit s, input bit rst_clk, input string tag);
    move_done = 1; side_to_move = s; move_resets_clock = rst_clk;
    tick(tag);
  endtask

  task automatic restart();
    new_game = 1;
    tick("newgame");
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 0;

    // Check tracking and release.
    do_eval(0, 1, 1, "chk_w");
    check_val("chk_w.explicit", int'(cw[0]), 1);
    check_val("chk_w.cb", int'(cb[0]), 0);
    do_eval(1, 0, 1, "safe_b");
    check_val("safe_b.cw", int'(cw[0]), 0);

    // Black mated, then a late resignation is ignored.
    do_eval(1, 1, 0, "mate_b");
    check_val("mate_b.ws", int'(ws[0]), 1);
    check_val("mate_b.er", int'(er[0]), 1);
    resign_white = 1;
    tick("post_mate_resign");
    check_val("post_mate.ws", int'(ws[0]), 1);

    // Halfmove draw after four quiet moves.
    restart();
    for (int k = 0; k < 4; k++) do_move(k[0], 0, "hm_draw");
    check_val("hm_draw.ws", int'(ws[0]), 3);
    check_val("hm_draw.er", int'(er[0]), 3);

    // Clock reset on the 3rd move prevents the draw.
    restart();
    for (int k = 0; k < 4; k++) do_move(k[0], (k == 2), "hm_reset");
    check_val("hm_reset.hm", int'(hm[0]), 1);
    check_val("hm_reset.ws", int'(ws[0]), 0);

    // Resignation beats flag-fall; double flag is a draw.
    restart();
    resign_black = 1; flag_black = 1;
    tick("resign_flag");
    check_val("resign_flag.er", int'(er[0]), 4);
    restart();
    flag_white = 1; flag_black = 1;
    tick("two_flags");
    check_val("two_flags.ws", int'(ws[0]), 3);

    // Mate in the same cycle as the halfmove limit is reached.
    restart();
    for (int k = 0; k < 3; k++) do_move(k[0], 0, "pre_mate");
    eval_valid = 1; side_to_move = 0; in_check = 1; has_legal_move = 0;
    move_done = 1;
    tick("mate_vs_hm");
    check_val("mate_vs_hm.ws", int'(ws[0]), 2);
    check_val("mate_vs_hm.er", int'(er[0]), 1);

    // Full-move cap on instance 1.
    restart();
    for (int k = 0; k < 4; k++) do_move(k[0], 1, "cap");
    check_val("cap.fm", int'(fm[1]), 3);
    check_val("cap.er", int'(er[1]), 6);

    // new_game, then an asynchronous reset between edges.
    restart();
    do_move(0, 0, "pre_rst");
    do_eval(1, 1, 1, "pre_rst_chk");
    #2;
    reset = 1;
    model_reset();
    #1;
    compare_all("async_rst");
    check_val("async_rst.cb", int'(cb[0]), 0);
    @(negedge clk);
    reset = 0;

    // Randomised play.
    for (int n = 0; n < 2000; n++) begin
      new_game          = ($urandom_range(0, 39) == 0);
      eval_valid        = $urandom_range(0, 1);
      side_to_move      = $urandom_range(0, 1);
      in_check          = ($urandom_range(0, 3) == 0);
      has_legal_move    = ($urandom_range(0, 24) != 0);
      move_done         = $urandom_range(0, 1);
      move_resets_clock = ($urandom_range(0, 2) == 0);
      resign_white      = ($urandom_range(0, 59) == 0);
      resign_black      = ($urandom_range(0, 59) == 0);
      flag_white        = ($urandom_range(0, 59) == 0);
      flag_black        = ($urandom_range(0, 59) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
